// File: rtl/alu_writeback_stage.sv
// ---------------------------------------------------------------------------
// alu_writeback_stage
//   Conditional-execution and writeback stage behind the ALU. Each accepted
//   op has its condition code evaluated against the architectural NZCV
//   register. A flag-setting op that passes updates NZCV on the accepting
//   edge. The op is then queued for the register file with We = pass.
//   Condition-failed ops are counted by a saturating counter.
//
// Ports
//   Clk, Rst_n         clock, asynchronous active-low reset
//   In_Valid/In_Ready  op handshake (In_Ready depends on queue occupancy only)
//   Result, Rd         ALU result and destination register
//   New_Flag, S, Cond  ALU-computed NZCV, flag-setting bit, condition code
//   Flag               architectural NZCV, fed back to the ALU
//   Out_Valid/Out_Ready head-of-queue handshake to the register file
//   Out_Result/Out_Rd/Out_We  head entry (zero when the queue is empty)
//   Fail_Cnt           saturating count of condition-failed ops
// ---------------------------------------------------------------------------
module alu_writeback_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Result,
  input  logic [3:0]       New_Flag,
  input  logic             S,
  input  logic [3:0]       Cond,
  input  logic [3:0]       Rd,
  output logic [3:0]       Flag,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out_Result,
  output logic [3:0]       Out_Rd,
  output logic             Out_We,
  output logic [15:0]      Fail_Cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  logic [3:0]    flag_q, flag_d;
  logic [15:0]   fail_q, fail_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [WIDTH-1:0] res_mem_q [DEPTH];
  logic [3:0]       rd_mem_q  [DEPTH];
  logic             we_mem_q  [DEPTH];

  logic cond_pass;
  logic push, pop, head_valid;
  logic fn, fz, fc, fv;

  assign {fn, fz, fc, fv} = flag_q;

  always_comb begin
    cond_pass = 1'b0;
    unique case (cond_e'(Cond))
      COND_EQ: cond_pass = fz;
      COND_NE: cond_pass = !fz;
      COND_CS: cond_pass = fc;
      COND_CC: cond_pass = !fc;
      COND_MI: cond_pass = fn;
      COND_PL: cond_pass = !fn;
      COND_VS: cond_pass = fv;
      COND_VC: cond_pass = !fv;
      COND_HI: cond_pass = fc && !fz;
      COND_LS: cond_pass = !fc || fz;
      COND_GE: cond_pass = (fn == fv);
      COND_LT: cond_pass = (fn != fv);
      COND_GT: cond_pass = !fz && (fn == fv);
      COND_LE: cond_pass = fz || (fn != fv);
      COND_AL: cond_pass = 1'b1;
      COND_NV: cond_pass = 1'b0;
    endcase
  end

  assign head_valid = (count_q != '0);
  assign In_Ready   = (count_q < CW'(DEPTH));
  assign push       = In_Valid && In_Ready;
  assign pop        = head_valid && Out_Ready;

  always_comb begin
    flag_d   = flag_q;
    fail_d   = fail_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (cond_pass && S) begin
        flag_d = New_Flag;
      end
      if (!cond_pass && (fail_q != '1)) begin
        fail_d = fail_q + 16'd1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      flag_q   <= '0;
      fail_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      flag_q   <= flag_d;
      fail_q   <= fail_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: entries are only observable through count_q,
  // and the outputs are forced to zero while the queue is empty.
  always_ff @(posedge Clk) begin
    if (push) begin
      res_mem_q[wr_ptr_q] <= Result;
      rd_mem_q[wr_ptr_q]  <= Rd;
      we_mem_q[wr_ptr_q]  <= cond_pass;
    end
  end

  assign Flag       = flag_q;
  assign Fail_Cnt   = fail_q;
  assign Out_Valid  = head_valid;
  assign Out_Result = head_valid ? res_mem_q[rd_ptr_q] : '0;
  assign Out_Rd     = head_valid ? rd_mem_q[rd_ptr_q]  : '0;
  assign Out_We     = head_valid ? we_mem_q[rd_ptr_q]  : 1'b0;

endmodule
